clock_divider: RTL and testbench

Parameterised integer clock divider for the PT2262/PT2272 encoder/decoder oscillator path. It derives a slow bit-timing clock from the fast system oscillator; at the 3 MHz system clock, the default ratio of 250 gives ≈12 kHz. The output is a registered, glitch-free square wave with a deterministic phase after reset. Optional logic balances the duty cycle for odd ratios.

---
 rtl/clock_divider.sv | 67 ++++++
 tb/tb_clock_divider.sv | 117 +++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// Integer clock divider: low for ceil(N/2) cycles, high for floor(N/2).
// Optional CLOCK_DIVIDER_BALANCED_DUTY_EN stretches odd-N high phase by half a cycle.
module clock_divider #(
   parameter int unsigned DIVIDER = 250
) (
   input  logic INPUT_CLK,
   input  logic RST,
   output logic OUTPUT_CLK
);

   localparam int unsigned NSAFE = (DIVIDER < 2) ? 2 : DIVIDER;
   localparam int unsigned W     = $clog2(NSAFE);
   localparam int unsigned L     = (NSAFE + 1) / 2;
   localparam logic [W-1:0] LAST_C = W'(NSAFE - 1);
   localparam logic [W-1:0] RISE_C = W'(L);

   if (DIVIDER < 2 || DIVIDER > 65535) begin : g_bad_divider
      $error("clock_divider: DIVIDER %0d outside 2..65535", DIVIDER);
   end

   logic [W-1:0] cnt_q, cnt_d;
   logic         base_q, base_d;

   // next count wraps at N-1; base sets at L and clears at 0
   always_comb begin
      cnt_d  = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
      base_d = base_q;
      if (cnt_d == RISE_C) begin
         base_d = 1'b1;
      end else if (cnt_d == '0) begin
         base_d = 1'b0;
      end
   end

   // counter and base output register
   always_ff @(posedge INPUT_CLK or negedge RST) begin
      if (!RST) begin
         cnt_q  <= '0;
         base_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         base_q <= base_d;
      end
   end

`ifdef CLOCK_DIVIDER_BALANCED_DUTY_EN
   if (NSAFE % 2 == 1) begin : g_odd
      logic base_n_q;

      // half-cycle delayed copy extends the high phase for odd ratios
      always_ff @(negedge INPUT_CLK or negedge RST) begin
         if (!RST) begin
            base_n_q <= 1'b0;
         end else begin
            base_n_q <= base_q;
         end
      end

      assign OUTPUT_CLK = base_q | base_n_q;
   end else begin : g_even
      assign OUTPUT_CLK = base_q;
   end
`else
   assign OUTPUT_CLK = base_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Randomised reset/run bench for clock_divider at N = 250, 2, 5, 4.
// Expected output derived arithmetically from the edge index since reset.
`timescale 1ns/1ps
module tb_clock_divider;

   logic clk;
   logic rst_n;
   logic out250, out2, out5, out4;

   int vectors;
   int miscompares;
   int k;

   clock_divider #(.DIVIDER(250)) u_d250 (
      .INPUT_CLK(clk), .RST(rst_n), .OUTPUT_CLK(out250));
   clock_divider #(.DIVIDER(2)) u_d2 (
      .INPUT_CLK(clk), .RST(rst_n), .OUTPUT_CLK(out2));
   clock_divider #(.DIVIDER(5)) u_d5 (
      .INPUT_CLK(clk), .RST(rst_n), .OUTPUT_CLK(out5));
   clock_divider #(.DIVIDER(4)) u_d4 (
      .INPUT_CLK(clk), .RST(rst_n), .OUTPUT_CLK(out4));

   initial clk = 1'b0;
   always #165 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s edge=%0d got=%b want=%b", tag, k, obs, exp);
      end
   endtask

   // base waveform: high when (edge mod N) lies in [L, N)
   function automatic logic f(int n, int j);
      int l;
      l = (n + 1) / 2;
      return (j > 0) && ((j % n) >= l);
   endfunction

   // phase 0: just after rising edge k; phase 1: just after following falling edge
   function automatic logic model(int n, int j, int phase);
      logic r;
      r = f(n, j);
`ifdef CLOCK_DIVIDER_BALANCED_DUTY_EN
      if (phase == 0 && (n % 2) == 1) r = f(n, j) | f(n, j - 1);
`endif
      return r;
   endfunction

   task automatic check_all(input int phase);
      check("n250", out250, model(250, k, phase));
      check("n2",   out2,   model(2,   k, phase));
      check("n5",   out5,   model(5,   k, phase));
      check("n4",   out4,   model(4,   k, phase));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_n250"}, out250, 1'b0);
      check({tag, "_n2"},   out2,   1'b0);
      check({tag, "_n5"},   out5,   1'b0);
      check({tag, "_n4"},   out4,   1'b0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         k++;
         #1 check_all(0);
         @(negedge clk);
         #1 check_all(1);
      end
   endtask

   // assert reset mid-cycle, confirm async clear, hold, release on falling edge
   task automatic pulse_reset(input int hold);
      #50 rst_n = 1'b0;
      #1 check_zero("async");
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1 check_zero("held");
      end
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      k           = 0;
      rst_n       = 1'b0;

      repeat (3) begin
         @(posedge clk);
         #1 check_zero("reset");
      end
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;

      run(750);
      run(180);
      pulse_reset(2);
      run(300);

      for (int t = 0; t < 6; t++) begin
         run($urandom_range(1, 600));
         pulse_reset($urandom_range(1, 4));
      end
      run(260);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
